// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux: registered one-hot grant plus binary select.
// Optional owner preemption after MAX_HOLD cycles is compiled in with `define ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [2:0] rel_pick;
   logic       do_grant;
   logic       do_idle;
   logic [1:0] win;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD out of range 2..255");
   end

   // {found, index} of the first set bit of r searching upward from p, wrapping 3->0.
   function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign rel_pick = pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;
   logic [2:0] preempt_pick;
   // In OWN, gnt is the owner's one-hot, so masking it out leaves only the challengers.
   assign preempt_pick = pick(req & ~gnt, ptr);
`endif

   always_comb begin
      do_grant = 1'b0;
      do_idle  = 1'b0;
      win      = rel_pick[1:0];
      case (state)
         IDLE: do_grant = rel_pick[2];
         OWN: begin
            if (!req[sel]) begin
               if (rel_pick[2]) do_grant = 1'b1;
               else             do_idle  = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt == HOLD_LAST && preempt_pick[2]) begin
               do_grant = 1'b1;
               win      = preempt_pick[1:0];
            end
`endif
         end
         default: do_idle = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'b00;
         busy  <= 1'b0;
         ptr   <= 2'b00;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= 8'd0;
`endif
      end else if (do_grant) begin
         state <= OWN;
         gnt   <= 4'b0001 << win;
         sel   <= win;
         busy  <= 1'b1;
         ptr   <= win + 2'd1;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= 8'd0;
`endif
      end else if (do_idle) begin
         // sel deliberately keeps the last owner so the mux output stays stable while idle.
         state <= IDLE;
         gnt   <= 4'b0000;
         busy  <= 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      else if (state == OWN && hold_cnt != HOLD_LAST) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
`endif
   end

endmodule
